// File: rtl/bayer_mosaic_writer_pkg.sv
// Shared CFA codes for the Bayer writer and address generator.
// Pattern, site symbol and FSM state encodings.
package bayer_mosaic_writer_pkg;

  typedef enum logic [1:0] {
    PAT_RGGB = 2'b00,
    PAT_GRBG = 2'b01,
    PAT_GBRG = 2'b10,
    PAT_BGGR = 2'b11
  } pat_e;

  typedef enum logic [1:0] {
    SYM_R  = 2'b00,
    SYM_GR = 2'b01,
    SYM_GB = 2'b10,
    SYM_B  = 2'b11
  } sym_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10,
    S_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/bayer_mosaic_writer_site_decode.sv
// Combinational CFA site decode, shared with the read side.
// Symbol is the row/col parity offset by the pattern code.
module bayer_site_decode
  import bayer_mosaic_writer_pkg::*;
(
  input  logic       row0,
  input  logic       col0,
  input  logic [1:0] patternSelect,
  output logic [1:0] symbol
);

  assign symbol = {row0, col0} ^ patternSelect;

endmodule

// File: rtl/bayer_mosaic_writer.sv
// RGB raster in, one CFA channel per site out to frame memory.
// FSM, row/col/address counters and a one-entry write register.
module bayer_mosaic_writer
  import bayer_mosaic_writer_pkg::*;
#(
  parameter int DIM_W  = 11,
  parameter int ADDR_W = 2 * DIM_W,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  rowMax,
  input  logic [DIM_W-1:0]  colMax,
  input  logic [1:0]        patternSelect,
  input  logic              pixValid,
  output logic              pixReady,
  input  logic [DATA_W-1:0] pixR,
  input  logic [DATA_W-1:0] pixG,
  input  logic [DATA_W-1:0] pixB,
  output logic              wrValid,
  input  logic              wrReady,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [DATA_W-1:0] wrData,
  output logic [1:0]        bayerSymbol,
  output logic              ready,
  output logic              done
);

  state_e state;
  state_e state_nx;

  logic [DIM_W-1:0]  row_max_q;
  logic [DIM_W-1:0]  col_max_q;
  logic [1:0]        pat_q;
  logic [DIM_W-1:0]  row;
  logic [DIM_W-1:0]  col;
  logic [ADDR_W-1:0] addr;

  logic              accept;
  logic              wr_fire;
  logic              last;
  logic              col_wrap;
  logic [1:0]        sym;
  logic [DATA_W-1:0] data_sel;

  bayer_site_decode u_site (
    .row0          (row[0]),
    .col0          (col[0]),
    .patternSelect (pat_q),
    .symbol        (sym)
  );

  assign ready    = (state == S_IDLE);
  assign done     = (state == S_DONE);
  assign pixReady = (state == S_RUN) &&
                    (!wrValid || wrReady);
  assign accept   = pixValid && pixReady;
  assign wr_fire  = wrValid && wrReady;
  assign col_wrap = (col == col_max_q);
  assign last     = (row == row_max_q) && col_wrap;

  always_comb begin
    data_sel = pixG;
    unique case (1'b1)
      (sym == SYM_R): data_sel = pixR;
      (sym == SYM_B): data_sel = pixB;
      default:        data_sel = pixG;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (accept && last) state_nx = S_DRAIN;
      S_DRAIN: if (wr_fire) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      row_max_q   <= '0;
      col_max_q   <= '0;
      pat_q       <= '0;
      row         <= '0;
      col         <= '0;
      addr        <= '0;
      wrValid     <= 1'b0;
      wrAddr      <= '0;
      wrData      <= '0;
      bayerSymbol <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        row_max_q <= rowMax;
        col_max_q <= colMax;
        pat_q     <= patternSelect;
        row       <= '0;
        col       <= '0;
        addr      <= '0;
      end
      // Pixel accept loads the write register and advances the raster.
      if (accept) begin
        wrAddr      <= addr;
        wrData      <= data_sel;
        bayerSymbol <= sym;
        addr        <= addr + 1'b1;
        if (col_wrap) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (accept)
        wrValid <= 1'b1;
      else if (wrReady)
        wrValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bayer_mosaic_writer.sv
// Randomized bench for bayer_mosaic_writer.
// Frame-level model: pixel index -> row/col -> site and channel.
module tb_bayer_mosaic_writer;

  localparam int DIM_W  = 11;
  localparam int ADDR_W = 2 * DIM_W;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DIM_W-1:0]  rowMax;
  logic [DIM_W-1:0]  colMax;
  logic [1:0]        patternSelect;
  logic              pixValid;
  logic              pixReady;
  logic [DATA_W-1:0] pixR;
  logic [DATA_W-1:0] pixG;
  logic [DATA_W-1:0] pixB;
  logic              wrValid;
  logic              wrReady;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic [1:0]        bayerSymbol;
  logic              ready;
  logic              done;

  always #5 clk = ~clk;

  bayer_mosaic_writer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .rowMax        (rowMax),
    .colMax        (colMax),
    .patternSelect (patternSelect),
    .pixValid      (pixValid),
    .pixReady      (pixReady),
    .pixR          (pixR),
    .pixG          (pixG),
    .pixB          (pixB),
    .wrValid       (wrValid),
    .wrReady       (wrReady),
    .wrAddr        (wrAddr),
    .wrData        (wrData),
    .bayerSymbol   (bayerSymbol),
    .ready         (ready),
    .done          (done)
  );

  typedef struct {
    int addr;
    int data;
    int sym;
  } wr_t;

  int checks = 0;
  int errors = 0;

  wr_t q[$];
  int  acc, total, cols, pat;
  bit  active, done_due, armed;
  int  cyc;

  int log_addr[$];
  int log_data[$];
  int log_sym[$];
  int log_cyc[$];

  int pv_pct, wr_pct, wr_mode, bp_cnt;
  bit pix_fixed;

  task automatic chk(string name,
                     logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic wr_t expect_px(int idx);
    wr_t e;
    int r, c, p;
    r = idx / cols;
    c = idx % cols;
    p = (((r % 2) * 2) + (c % 2)) ^ pat;
    e.addr = idx;
    e.sym  = p;
    if (p == 0)      e.data = int'(pixR);
    else if (p == 3) e.data = int'(pixB);
    else             e.data = int'(pixG);
    return e;
  endfunction

  task automatic model_check();
    bit pr_exp, take;
    wr_t e;
    cyc++;
    pr_exp = active && (acc < total) &&
             (q.size() == 0 || wrReady);
    if (armed) begin
      chk("ready", ready, !active && !done_due);
      chk("done", done, done_due);
      chk("wrValid", wrValid, q.size() != 0);
      chk("pixReady", pixReady, pr_exp);
      if (wrValid && q.size() != 0) begin
        chk("wrAddr", wrAddr, q[0].addr);
        chk("wrData", wrData, q[0].data);
        chk("bayerSymbol", bayerSymbol, q[0].sym);
      end
    end
    if (rst) begin
      q.delete();
      active   = 0;
      done_due = 0;
      acc      = 0;
      armed    = 1;
      return;
    end
    take = pixValid && pr_exp;
    if (wrValid && wrReady && q.size() != 0) begin
      log_addr.push_back(q[0].addr);
      log_data.push_back(q[0].data);
      log_sym.push_back(q[0].sym);
      log_cyc.push_back(cyc);
      void'(q.pop_front());
    end
    done_due = 0;
    if (start && !active && !done_due && ready) begin
      active = 1;
      acc    = 0;
      cols   = int'(colMax) + 1;
      total  = (int'(rowMax) + 1) * cols;
      pat    = int'(patternSelect);
    end else if (take) begin
      e = expect_px(acc);
      q.push_back(e);
      acc++;
    end
    if (active && acc == total && q.size() == 0) begin
      active   = 0;
      done_due = 1;
    end
  endtask

  task automatic drive();
    pixValid = ($urandom_range(99) < pv_pct);
    if (pix_fixed) begin
      pixR = 8'h11;
      pixG = 8'h22;
      pixB = 8'h33;
    end else begin
      pixR = DATA_W'($urandom);
      pixG = DATA_W'($urandom);
      pixB = DATA_W'($urandom);
    end
    if (wr_mode == 1) begin
      if (bp_cnt < 10)
        wrReady = (bp_cnt % 2 == 0);
      else if (bp_cnt < 15)
        wrReady = 1'b0;
      else
        wrReady = 1'b1;
      bp_cnt++;
    end else begin
      wrReady = ($urandom_range(99) < wr_pct);
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_frame(input int rm, input int cm,
                           input int pt, input int tmo,
                           input int mid_start);
    int n;
    rowMax        = DIM_W'(rm);
    colMax        = DIM_W'(cm);
    patternSelect = 2'(pt);
    bp_cnt        = 0;
    start         = 1'b1;
    step();
    start         = 1'b0;
    rowMax        = DIM_W'($urandom);
    colMax        = DIM_W'($urandom);
    patternSelect = 2'($urandom);
    n = 0;
    while ((active || done_due) && n < tmo) begin
      start = (n == mid_start);
      step();
      n++;
    end
    start = 1'b0;
    chk("frame_timeout", n < tmo, 1);
  endtask

  int base;
  int exp_sym[8] = '{0, 1, 0, 1, 2, 3, 2, 3};
  int exp_d1[4]  = '{'h22, 'h11, 'h33, 'h22};
  int exp_d2[4]  = '{'h22, 'h33, 'h11, 'h22};
  int exp_d3[4]  = '{'h33, 'h22, 'h22, 'h11};

  initial begin
    rst = 1'b1;
    start = 1'b0;
    rowMax = '0;
    colMax = '0;
    patternSelect = '0;
    pixValid = 1'b0;
    pixR = '0;
    pixG = '0;
    pixB = '0;
    wrReady = 1'b0;
    pv_pct = 100;
    wr_pct = 100;
    wr_mode = 0;
    pix_fixed = 0;
    bp_cnt = 0;
    cyc = 0;
    acc = 0;
    total = 0;
    cols = 1;
    pat = 0;
    active = 0;
    done_due = 0;
    armed = 0;
    step();
    step();
    rst = 1'b0;
    chk("rst_ready", ready, 1);
    chk("rst_pixReady", pixReady, 0);
    chk("rst_wrValid", wrValid, 0);
    chk("rst_done", done, 0);
    chk("rst_wrAddr", wrAddr, 0);
    chk("rst_wrData", wrData, 0);
    chk("rst_sym", bayerSymbol, 0);

    // 4x4 RGGB at full throughput
    base = log_addr.size();
    run_frame(3, 3, 0, 200, -1);
    chk("t1_count", log_addr.size() - base, 16);
    if (log_addr.size() - base == 16) begin
      for (int i = 0; i < 16; i++) begin
        chk("t1_addr", log_addr[base+i], i);
        chk("t1_sym", log_sym[base+i], exp_sym[i%8]);
      end
      chk("t1_span",
          log_cyc[base+15] - log_cyc[base], 15);
    end

    // 2x2 frames, each other pattern
    pix_fixed = 1;
    for (int p = 1; p < 4; p++) begin
      base = log_addr.size();
      run_frame(1, 1, p, 100, -1);
      chk("t2_count", log_addr.size() - base, 4);
      if (log_addr.size() - base == 4) begin
        for (int i = 0; i < 4; i++) begin
          if (p == 1)
            chk("t2_grbg", log_data[base+i], exp_d1[i]);
          else if (p == 2)
            chk("t2_gbrg", log_data[base+i], exp_d2[i]);
          else
            chk("t2_bggr", log_data[base+i], exp_d3[i]);
        end
      end
    end
    pix_fixed = 0;

    // backpressure pattern
    wr_mode = 1;
    base = log_addr.size();
    run_frame(3, 3, 2, 300, -1);
    chk("t3_count", log_addr.size() - base, 16);
    if (log_addr.size() - base == 16)
      for (int i = 0; i < 16; i++)
        chk("t3_addr", log_addr[base+i], i);
    wr_mode = 0;

    // single-pixel frame
    base = log_addr.size();
    run_frame(0, 0, 3, 50, -1);
    chk("t4_count", log_addr.size() - base, 1);
    if (log_addr.size() - base == 1)
      chk("t4_addr", log_addr[base], 0);
    chk("t4_ready", ready, 1);

    // start mid-frame ignored
    pv_pct = 80;
    wr_pct = 80;
    base = log_addr.size();
    run_frame(7, 7, 1, 1000, 10);
    chk("t4_mid_count", log_addr.size() - base, 64);

    // reset at pixel 20, then restart
    rowMax = 7;
    colMax = 7;
    patternSelect = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    begin
      int n = 0;
      while (acc < 20 && n < 1000) begin
        step();
        n++;
      end
      chk("t5_reach20", acc, 20);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_wrValid", wrValid, 0);
    chk("t5_ready", ready, 1);
    base = log_addr.size();
    run_frame(7, 7, 0, 1000, -1);
    chk("t5_count", log_addr.size() - base, 64);
    if (log_addr.size() - base == 64)
      chk("t5_first", log_addr[base], 0);

    // large random frame
    pv_pct = 70;
    wr_pct = 70;
    base = log_addr.size();
    run_frame(3, 2047, 2, 50000, -1);
    chk("t6_count", log_addr.size() - base, 8192);
    if (log_addr.size() - base == 8192)
      chk("t6_last", log_addr[base+8191], 8191);

    step();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
